// File: rtl/seq_pkg.sv
// Shared types and constants for the DDS pattern sequencer and its note ROM.
package seq_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, LATCH, WAIT} state_t;

   localparam int         NEW_NOTE_BIT   = 7;
   localparam logic [7:0] NOTE_OFF_CODE  = 8'h7F;
   localparam int         NUM_NOTES      = 96;
   localparam int         MIN_ROW_PERIOD = 4;

   // Equal-tempered tuning word for MIDI-style note n (A4 = note 69 = 440 Hz),
   // rounded to nearest. Only ever evaluated at elaboration.
   function automatic longint note_word(input int n, input int pw, input real clk_hz);
      real f;
      f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0)) * (2.0 ** real'(pw)) / clk_hz;
      return longint'($floor(f + 0.5));
   endfunction

endpackage

// File: rtl/note_freq_rom.sv
// Note number -> DDS frequency word, one-cycle registered read.
// Out-of-range addresses yield 0 with invalid set; invalid also rests high
// after reset/clear so it can directly serve as the inverted voice gate.
module note_freq_rom
   import seq_pkg::*;
#(
   parameter int PHASE_WIDTH = 32,
   parameter int CLK_HZ      = 50_000_000
)(
   input  logic                   clk,
   input  logic                   rst_active_high,
   input  logic                   clr,
   input  logic                   en,
   input  logic [6:0]             addr,
   output logic [PHASE_WIDTH-1:0] freq_q,
   output logic                   invalid_q
);

   logic [PHASE_WIDTH-1:0] tab [NUM_NOTES];

   for (genvar i = 0; i < NUM_NOTES; i++) begin : g_tab
      localparam logic [PHASE_WIDTH-1:0] W = PHASE_WIDTH'(note_word(i, PHASE_WIDTH, real'(CLK_HZ)));
      assign tab[i] = W;
   end

   // Registered lookup; clear discards any in-flight result
   always_ff @(posedge clk) begin
      if (rst_active_high || clr) begin
         freq_q    <= '0;
         invalid_q <= 1'b1;
      end else if (en) begin
         if (addr < 7'(NUM_NOTES)) begin
            freq_q    <= tab[addr];
            invalid_q <= 1'b0;
         end else begin
            freq_q    <= '0;
            invalid_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dds_pattern_sequencer.sv
// Tracker row sequencer feeding the DDS sine voice frequency word and gate.
// Optional feature macro: SEQ_LOOP_EN adds the loop_en port (wrap after last row).
module dds_pattern_sequencer
   import seq_pkg::*;
#(
   parameter int PHASE_WIDTH = 32,
   parameter int ROWS        = 64,
   parameter int CLK_HZ      = 50_000_000,
   parameter int CNT_WIDTH   = 24
)(
   input  logic                     clk,
   input  logic                     rst_active_high,
   input  logic                     start,
   input  logic                     stop,
   input  logic [CNT_WIDTH-1:0]     clocks_per_row,
`ifdef SEQ_LOOP_EN
   input  logic                     loop_en,
`endif
   output logic [$clog2(ROWS)-1:0]  row_addr,
   input  logic [7:0]               row_data,
   output logic [PHASE_WIDTH-1:0]   freq_word,
   output logic                     gate,
   output logic                     busy,
   output logic                     done
);

   localparam int RW = $clog2(ROWS);

   state_t               state, nxt;
   logic [RW-1:0]        row;
   logic [CNT_WIDTH-1:0] cnt, period;
   logic                 looping, last_row, row_end, start_ok;
   logic                 rom_en, rom_clr, rom_invalid;

`ifdef SEQ_LOOP_EN
   assign looping = loop_en;
`else
   assign looping = 1'b0;
`endif

   assign last_row = (row == RW'(ROWS - 1));
   assign row_end  = (state == WAIT) && (cnt == CNT_WIDTH'(1));
   assign start_ok = (state == IDLE) && start && !stop;

   // State register
   always_ff @(posedge clk) begin
      if (rst_active_high) state <= IDLE;
      else                 state <= nxt;
   end

   // Next state; stop wins over everything, including a same-cycle start
   always_comb begin
      nxt = state;
      if (stop) nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (start) nxt = FETCH;
            FETCH:   nxt = LATCH;
            LATCH:   nxt = WAIT;
            WAIT:    if (row_end) nxt = (!last_row || looping) ? FETCH : IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // Outputs and ROM controls; hold codes leave the ROM register untouched
   always_comb begin
      busy     = (state != IDLE);
      row_addr = row;
      rom_en   = (state == LATCH) && !stop &&
                 (row_data[NEW_NOTE_BIT] || row_data == NOTE_OFF_CODE);
      rom_clr  = stop || start_ok;
   end

   // Row index, period latch and row countdown (counts through LATCH and WAIT
   // so the next FETCH lands exactly P cycles after the previous one)
   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         row    <= '0;
         cnt    <= '0;
         period <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start_ok) begin
               row    <= '0;
               period <= (clocks_per_row < CNT_WIDTH'(MIN_ROW_PERIOD)) ?
                         CNT_WIDTH'(MIN_ROW_PERIOD) : clocks_per_row;
            end
            FETCH: cnt <= period - CNT_WIDTH'(1);
            LATCH, WAIT: begin
               cnt <= cnt - CNT_WIDTH'(1);
               if (row_end) begin
                  if (!last_row)    row  <= row + RW'(1);
                  else if (looping) row  <= '0;
                  else              done <= !stop;
               end
            end
            default: ;
         endcase
      end
   end

   // Note code -> frequency word; code bits [6:0] address the ROM directly,
   // so note-off (7F) and notes >= 96 both land out of range and mute
   note_freq_rom #(
      .PHASE_WIDTH(PHASE_WIDTH),
      .CLK_HZ     (CLK_HZ)
   ) u_rom (
      .clk            (clk),
      .rst_active_high(rst_active_high),
      .clr            (rom_clr),
      .en             (rom_en),
      .addr           (row_data[6:0]),
      .freq_q         (freq_word),
      .invalid_q      (rom_invalid)
   );

   assign gate = !rom_invalid;

endmodule

// File: tb/tb_dds_pattern_sequencer.sv
// Self-checking bench for dds_pattern_sequencer (ROWS=4, 50 MHz, 32-bit phase).
module tb_dds_pattern_sequencer;

   localparam int PW     = 32;
   localparam int ROWS   = 4;
   localparam int CLK_HZ = 50_000_000;
   localparam int CW     = 24;
`ifdef SEQ_LOOP_EN
   localparam bit HAS_LOOP = 1'b1;
`else
   localparam bit HAS_LOOP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_active_high, start, stop;
   logic [CW-1:0] clocks_per_row;
`ifdef SEQ_LOOP_EN
   logic          loop_en;
`endif
   logic [1:0]    row_addr;
   logic [7:0]    row_data;
   logic [PW-1:0] freq_word;
   logic          gate, busy, done;

   logic [7:0]    pat [ROWS];
   int            checks = 0;
   int            failures = 0;
   int            busy_cnt, done_cnt;

   always #5 clk = ~clk;

   // Pattern RAM: one-cycle read latency
   always @(posedge clk) row_data <= pat[row_addr];

   dds_pattern_sequencer #(
      .PHASE_WIDTH(PW), .ROWS(ROWS), .CLK_HZ(CLK_HZ), .CNT_WIDTH(CW)
   ) dut (
      .clk            (clk),
      .rst_active_high(rst_active_high),
      .start          (start),
      .stop           (stop),
      .clocks_per_row (clocks_per_row),
`ifdef SEQ_LOOP_EN
      .loop_en        (loop_en),
`endif
      .row_addr       (row_addr),
      .row_data       (row_data),
      .freq_word      (freq_word),
      .gate           (gate),
      .busy           (busy),
      .done           (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   // Frequency word straight from the tuning formula
   function automatic logic [PW-1:0] ref_freq(input int n);
      real hz, w;
      hz = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
      w  = hz * 4294967296.0 / real'(CLK_HZ);
      return PW'(longint'($floor(w + 0.5)));
   endfunction

   // Effect of one row code on the voice
   task automatic apply_code(input logic [7:0] c, inout logic [PW-1:0] f, inout logic g);
      if (c[7]) begin
         if (int'(c[6:0]) < 96) begin f = ref_freq(int'(c[6:0])); g = 1'b1; end
         else begin f = '0; g = 1'b0; end
      end else if (c == 8'h7F) begin
         f = '0; g = 1'b0;
      end
   endtask

   // Start playback and compare every cycle against a timeline model:
   // cycle k after start is row (k/P) mod ROWS, a row's code takes effect at
   // k mod P == 2, natural end at k == ROWS*P. stop_k / rst_k abort playback.
   task automatic play(input int cpr, input bit loop, input int ncyc,
                       input int stop_k, input int rst_k);
      int            p, total;
      bit            looping, stopped, exp_busy, exp_done;
      logic [PW-1:0] f_exp;
      logic          g_exp;
      looping  = loop & HAS_LOOP;
      p        = (cpr < 4) ? 4 : cpr;
      total    = ROWS * p;
      busy_cnt = 0;
      done_cnt = 0;
      stopped  = 1'b0;
      f_exp    = '0;
      g_exp    = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      clocks_per_row = CW'(cpr);
`ifdef SEQ_LOOP_EN
      loop_en = loop;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         stop            = (k == stop_k);
         rst_active_high = (k == rst_k);
         start           = (k == p + 3);
         clocks_per_row  = CW'($urandom_range(1, 50));
         if (!stopped && (looping || k < total) && (k % p) == 2)
            apply_code(pat[(k / p) % ROWS], f_exp, g_exp);
         exp_busy = !stopped && (looping || k < total);
         exp_done = !stopped && !looping && (k == total);
         @(negedge clk);
         chk("busy", busy, exp_busy);
         chk("done", done, exp_done);
         chk("freq_word", freq_word, f_exp);
         chk("gate", gate, g_exp);
         if (exp_busy) chk("row_addr", row_addr, (k / p) % ROWS);
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (k == stop_k || k == rst_k) begin
            stopped = 1'b1; f_exp = '0; g_exp = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; stop = 1'b0; rst_active_high = 1'b0;
   endtask

   initial begin
      int cpr;
      rst_active_high = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      clocks_per_row = '0;
`ifdef SEQ_LOOP_EN
      loop_en = 1'b0;
`endif
      for (int i = 0; i < ROWS; i++) pat[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_row_addr", row_addr, 0);
      chk("rst_freq", freq_word, 0);
      chk("rst_gate", gate, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1;
      rst_active_high = 1'b0;

      // A4 then holds
      pat[0] = 8'hC5; pat[1] = 8'h01; pat[2] = 8'h02; pat[3] = 8'h03;
      play(10, 1'b0, 46, -1, -1);
      chk("busy_len_p10", busy_cnt, 40);
      chk("done_once", done_cnt, 1);
      chk("held_freq_a4", freq_word, 37796);
      chk("held_gate_a4", gate, 1);

      // Minimum period clamp
      for (int i = 0; i < ROWS; i++) pat[i] = 8'($urandom_range(0, 255));
      play(1, 1'b0, 20, -1, -1);
      chk("busy_len_clamp", busy_cnt, 16);

      // Note off, out-of-range note, note 0
      pat[0] = 8'hC5; pat[1] = 8'h7F; pat[2] = 8'hE4; pat[3] = 8'h80;
      cpr = $urandom_range(4, 12);
      play(cpr, 1'b0, ROWS * cpr + 3, -1, -1);
      chk("held_freq_n0", freq_word, 702);
      chk("held_gate_n0", gate, 1);

      // Random patterns and periods
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < ROWS; i++) pat[i] = 8'($urandom_range(0, 255));
         cpr = $urandom_range(1, 9);
         play(cpr, 1'b0, ROWS * ((cpr < 4) ? 4 : cpr) + 3, -1, -1);
      end

      // Mid-row stop at FETCH+5 of row 2
      pat[0] = 8'hC5; pat[1] = 8'hC9; pat[2] = 8'hBC; pat[3] = 8'h01;
      play(10, 1'b0, 40, 25, -1);
      chk("stop_no_done", done_cnt, 0);

      // start+stop together is ignored; start alone next cycle plays
      @(posedge clk); #1;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("simul_ignored", busy, 0);
      play(5, 1'b0, 24, -1, -1);

      // Reset mid-WAIT
      for (int i = 0; i < ROWS; i++) pat[i] = 8'($urandom_range(128, 200));
      play(6, 1'b1, 30, -1, 16);
      @(negedge clk);
      chk("post_rst_row_addr", row_addr, 0);

`ifdef SEQ_LOOP_EN
      // Loop: wrap period stays P, no done, runs until stop
      for (int i = 0; i < ROWS; i++) pat[i] = 8'($urandom_range(0, 255));
      play(5, 1'b1, ROWS * 5 * 2 + 6, ROWS * 5 * 2 + 3, -1);
      chk("loop_no_done", done_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
